// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory read port, branch redirect/halt controls
// and the decode-side valid/ready instruction stream.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 8
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic          imem_re;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          halt;
    logic          ins_valid;
    logic          ins_ready;
    logic [IW-1:0] ins_data;
    logic [AW-1:0] ins_pc;
    logic [LW-1:0] level;

    modport master (
        output imem_re, imem_addr, ins_valid, ins_data, ins_pc, level,
        input  imem_rdata, redirect, redirect_pc, halt, ins_ready
    );

    modport slave (
        input  imem_re, imem_addr, ins_valid, ins_data, ins_pc, level,
        output imem_rdata, redirect, redirect_pc, halt, ins_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues synchronous memory reads and buffers
// returned instructions in a credit-controlled prefetch FIFO; redirect flushes everything.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW:0] DEPTH_C = (LW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t         state_r;
    logic [AW-1:0]  fetch_pc_r;
    logic           inflight_r;
    logic [AW-1:0]  inflight_pc_r;
    logic [LW-1:0]  level_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [IW-1:0]  data_mem_r [DEPTH];
    logic [AW-1:0]  pc_mem_r   [DEPTH];

    logic           credit_s;
    logic           issue_s;
    logic           push_s;
    logic           pop_s;

    // Credit counts the in-flight read but never this cycle's pop, so a push cannot overflow.
    assign credit_s = ({1'b0, level_r} + {{LW{1'b0}}, inflight_r}) < DEPTH_C;
    assign issue_s  = (state_r == ST_RUN) && !bus.redirect && credit_s;
    assign push_s   = inflight_r && !bus.redirect;
    assign pop_s    = (level_r != {LW{1'b0}}) && bus.ins_ready && !bus.redirect;

    assign bus.imem_re   = issue_s;
    assign bus.imem_addr = fetch_pc_r;
    assign bus.ins_valid = (level_r != {LW{1'b0}});
    assign bus.ins_data  = data_mem_r[rd_ptr_r];
    assign bus.ins_pc    = pc_mem_r[rd_ptr_r];
    assign bus.level     = level_r;

    // Fetch FSM, PC sequencing and in-flight tracking; redirect overrides issue and halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= {AW{1'b0}};
            inflight_r    <= 1'b0;
            inflight_pc_r <= {AW{1'b0}};
        end else begin
            inflight_r    <= issue_s;
            inflight_pc_r <= fetch_pc_r;
            if (bus.redirect) begin
                fetch_pc_r <= bus.redirect_pc;
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + AW'(1'b1);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            case (state_r)
                ST_IDLE: state_r <= ST_RUN;
                ST_RUN:  state_r <= (bus.halt && !bus.redirect) ? ST_HALT : ST_RUN;
                ST_HALT: state_r <= bus.halt ? ST_HALT : ST_RUN;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Prefetch FIFO storage, pointers and occupancy; a redirect empties it and drops the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r  <= {LW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= {IW{1'b0}};
                pc_mem_r[i]   <= {AW{1'b0}};
            end
        end else if (bus.redirect) begin
            level_r  <= {LW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= bus.imem_rdata;
                pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
                wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle model + scoreboard of expected {pc,data} per issued read,
// plus directed checks for latency, saturation, redirect, wrap, halt and async reset.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int IW    = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [IW-1:0]  imem [256];
    logic [15:0]    sb [$];
    logic [15:0]    pop_log [$];

    int             m_state;
    int             m_level;
    int             m_inflight;
    logic [AW-1:0]  m_pc;

    fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Synchronous instruction memory: data one cycle after the read strobe
    always @(posedge clk) begin
        if (bus.imem_re === 1'b1) bus.imem_rdata <= imem[bus.imem_addr];
    end

    // Cycle model and scoreboard, evaluated mid-cycle on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_re",    bus.imem_re,   0);
            chk("rst_addr",  bus.imem_addr, 0);
            chk("rst_valid", bus.ins_valid, 0);
            chk("rst_level", bus.level,     0);
            sb.delete();
            m_state    <= M_IDLE;
            m_level    <= 0;
            m_inflight <= 0;
            m_pc       <= 8'h00;
        end else begin
            automatic bit   exp_re;
            automatic bit   pop;
            automatic int   nl;
            automatic logic [15:0] e;
            exp_re = (m_state == M_RUN) && !bus.redirect && ((m_level + m_inflight) < DEPTH);
            pop    = bus.ins_valid && bus.ins_ready && !bus.redirect;
            chk("imem_re", bus.imem_re, exp_re);
            if (exp_re) chk("imem_addr", bus.imem_addr, m_pc);
            chk("level", bus.level, m_level);
            chk("ins_valid", bus.ins_valid, (m_level != 0));
            chk("overflow", (bus.level <= 3'd4), 1'b1);
            if (pop) begin
                if (sb.size() == 0) begin
                    chk("sb_empty_pop", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("pop_pc",   bus.ins_pc,   e[15:8]);
                    chk("pop_data", bus.ins_data, e[7:0]);
                end
                pop_log.push_back({bus.ins_pc, bus.ins_data});
            end
            if (bus.redirect) begin
                sb.delete();
                m_level    <= 0;
                m_inflight <= 0;
                m_pc       <= bus.redirect_pc;
            end else begin
                nl = m_level + m_inflight - (pop ? 1 : 0);
                m_level <= nl;
                if (exp_re) begin
                    sb.push_back({m_pc, imem[m_pc]});
                    m_pc <= m_pc + 8'h01;
                end
                m_inflight <= exp_re ? 1 : 0;
            end
            case (m_state)
                M_IDLE:  m_state <= M_RUN;
                M_RUN:   m_state <= (bus.halt && !bus.redirect) ? M_HALT : M_RUN;
                default: m_state <= bus.halt ? M_HALT : M_RUN;
            endcase
        end
    end

    initial begin
        automatic int cycles;
        automatic logic [15:0] e;
        automatic logic [7:0] exp4 [4];
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) imem[i] = 8'(i + 16);
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        bus.halt        = 1'b0;
        bus.ins_ready   = 1'b0;
        #2;
        chk("reset_data", bus.ins_data, 0);
        chk("reset_pc",   bus.ins_pc,   0);
        cyc(3);

        // 1: reset release latency and first instructions
        pop_log.delete();
        rst_n         = 1'b1;
        bus.ins_ready = 1'b1;
        cycles = 0;
        while (bus.ins_valid !== 1'b1 && cycles < 20) begin
            cyc(1);
            cycles++;
        end
        chk("first_valid_latency", cycles, 3);
        cyc(3);
        chk("t1_count", (pop_log.size() >= 3), 1'b1);
        if (pop_log.size() >= 3) begin
            chk("t1_pop0", pop_log[0], 16'h0010);
            chk("t1_pop1", pop_log[1], 16'h0111);
            chk("t1_pop2", pop_log[2], 16'h0212);
        end

        // 2: stall decode until the queue saturates, then drain and stream
        bus.ins_ready = 1'b0;
        cyc(10);
        chk("t2_full_level", bus.level, 4);
        chk("t2_full_re",    bus.imem_re, 0);
        bus.ins_ready = 1'b1;
        cyc(12);

        // 3: redirect while level=3 with a read in flight
        bus.ins_ready = 1'b0;
        cycles = 0;
        while (bus.level !== 3'd3 && cycles < 10) begin
            cyc(1);
            cycles++;
        end
        chk("t3_reach_level3", bus.level, 3);
        pop_log.delete();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        bus.ins_ready   = 1'b1;
        cyc(1);
        bus.redirect = 1'b0;
        chk("t3_flushed_level", bus.level, 0);
        cyc(6);
        chk("t3_count", (pop_log.size() >= 1), 1'b1);
        if (pop_log.size() >= 1) chk("t3_first_pop", pop_log[0], 16'h4050);

        // 4: address wrap from FE
        exp4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        pop_log.delete();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        cyc(1);
        bus.redirect = 1'b0;
        cyc(8);
        chk("t4_count", (pop_log.size() >= 4), 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_log.size()) begin
                e = pop_log[i];
                chk("t4_wrap_pc", e[15:8], exp4[i]);
            end
        end

        // back-to-back redirects: the later target wins
        pop_log.delete();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h80;
        cyc(1);
        bus.redirect_pc = 8'h90;
        cyc(1);
        bus.redirect = 1'b0;
        cyc(6);
        chk("b2b_count", (pop_log.size() >= 1), 1'b1);
        if (pop_log.size() >= 1) chk("b2b_first_pop", pop_log[0], 16'h90A0);

        // 5: halt drains without issuing, then resumes sequentially
        pop_log.delete();
        bus.halt = 1'b1;
        for (int i = 1; i < 6; i++) begin
            cyc(1);
            chk("t5_halt_re", bus.imem_re, 0);
        end
        cyc(1);
        bus.halt = 1'b0;
        chk("t5_drained", bus.level, 0);
        chk("t5_halt_exit_re", bus.imem_re, 0);
        cyc(8);
        chk("t5_count", (pop_log.size() >= 6), 1'b1);
        for (int i = 1; i < pop_log.size(); i++) begin
            chk("t5_seq", pop_log[i][15:8], 8'(pop_log[i-1][15:8] + 8'h01));
        end

        // 6: asynchronous reset between clock edges
        cyc(3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_re",    bus.imem_re,   0);
        chk("t6_addr",  bus.imem_addr, 0);
        chk("t6_valid", bus.ins_valid, 0);
        chk("t6_data",  bus.ins_data,  0);
        chk("t6_pc",    bus.ins_pc,    0);
        chk("t6_level", bus.level,     0);
        cyc(2);
        pop_log.delete();
        rst_n = 1'b1;
        cyc(8);
        chk("t6_count", (pop_log.size() >= 1), 1'b1);
        if (pop_log.size() >= 1) chk("t6_first_pop", pop_log[0], 16'h0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
